// File: rtl/mcu_pkg.sv
// Shared constants for the 14-bit-instruction MCU core: widths, NOP and the
// opcode match patterns used by the fetch unit's program-flow decode.
package mcu_pkg;
  localparam int PC_W    = 11;
  localparam int INSTR_W = 14;

  localparam logic [INSTR_W-1:0] NOP_WORD    = 14'h0000;
  localparam logic [INSTR_W-1:0] GOTO_MASK   = 14'h3800;
  localparam logic [INSTR_W-1:0] GOTO_VAL    = 14'h2800;
  localparam logic [INSTR_W-1:0] CALL_MASK   = 14'h3800;
  localparam logic [INSTR_W-1:0] CALL_VAL    = 14'h2000;
  localparam logic [INSTR_W-1:0] RETURN_MASK = 14'h3FFF;
  localparam logic [INSTR_W-1:0] RETURN_VAL  = 14'h0008;
  localparam logic [INSTR_W-1:0] RETLW_MASK  = 14'h3C00;
  localparam logic [INSTR_W-1:0] RETLW_VAL   = 14'h3400;

  typedef enum logic [2:0] {FL_SEQ, FL_GOTO, FL_CALL, FL_RET, FL_SKIP} flow_e;

  function automatic logic op_match(input logic [INSTR_W-1:0] ir,
                                    input logic [INSTR_W-1:0] mask,
                                    input logic [INSTR_W-1:0] val);
    return (ir & mask) == val;
  endfunction
endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack: DEPTH x W register file, wrapping pointer,
// and a saturating depth counter that only drives the sticky ovf/unf flags.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH)-1:0]   sp,
  output logic                       ovf,
  output logic                       unf
);
  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp_dec;
  logic [CNT_W-1:0] depth;

  assign sp_dec   = sp - SP_W'(1);
  assign pop_data = mem[sp_dec];

  // Contents are deliberately not reset; only the pointer state is.
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
      if (depth == CNT_W'(DEPTH)) ovf <= 1'b1;
      else                        depth <= depth + CNT_W'(1);
    end else if (pop) begin
      sp <= sp_dec;
      if (depth == '0) unf <= 1'b1;
      else             depth <= depth - CNT_W'(1);
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage of the 2-stage MCU pipeline: PC, IR, program-flow decode and
// the next-PC priority mux; transfers and skips insert a single bubble.
module pc_fetch_unit
  import mcu_pkg::*;
#(
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = 11'h000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_in,
  input  logic                           skip_in,
  input  logic [INSTR_W-1:0]             Rom_data_in,
  output logic [PC_W-1:0]                Rom_addr_out,
  output logic [INSTR_W-1:0]             ir_out,
  output logic                           ir_valid_out,
  output logic [$clog2(STACK_DEPTH)-1:0] sp_out,
  output logic                           stack_ovf,
  output logic                           stack_unf
);
  logic [PC_W-1:0]    pc, pc_next, pop_data;
  logic [INSTR_W-1:0] ir, ir_next;
  logic               ir_vld, ir_vld_next;
  logic               push, pop;
  flow_e              flow;

  // Bubbles never decode as transfers; transfers outrank a stray skip.
  always_comb begin
    flow = FL_SEQ;
    if (ir_vld) begin
      if      (op_match(ir, GOTO_MASK, GOTO_VAL))     flow = FL_GOTO;
      else if (op_match(ir, CALL_MASK, CALL_VAL))     flow = FL_CALL;
      else if (op_match(ir, RETURN_MASK, RETURN_VAL) ||
               op_match(ir, RETLW_MASK, RETLW_VAL))   flow = FL_RET;
      else if (skip_in)                               flow = FL_SKIP;
    end else if (skip_in) begin
      flow = FL_SKIP;
    end
  end

  assign push = !stall_in && (flow == FL_CALL);
  assign pop  = !stall_in && (flow == FL_RET);

  always_comb begin
    pc_next     = pc + PC_W'(1);
    ir_next     = NOP_WORD;
    ir_vld_next = 1'b0;
    case (flow)
      FL_GOTO, FL_CALL: pc_next = ir[PC_W-1:0];
      FL_RET:           pc_next = pop_data;
      FL_SKIP:          ;
      default: begin
        ir_next     = Rom_data_in;
        ir_vld_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_VECTOR;
      ir     <= NOP_WORD;
      ir_vld <= 1'b0;
    end else if (!stall_in) begin
      pc     <= pc_next;
      ir     <= ir_next;
      ir_vld <= ir_vld_next;
    end
  end

  // pc already points past the CALL, so it is the return address.
  return_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .pop_data  (pop_data),
    .sp        (sp_out),
    .ovf       (stack_ovf),
    .unf       (stack_unf)
  );

  assign Rom_addr_out = pc;
  assign ir_out       = ir;
  assign ir_valid_out = ir_vld;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector tables run through a scoreboard
// queue, plus hand sequences for overflow, underflow, stall and async reset.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        skip_in = 1'b0;
  logic [13:0] Rom_data_in;
  logic [10:0] Rom_addr_out;
  logic [13:0] ir_out;
  logic        ir_valid_out;
  logic [2:0]  sp_out;
  logic        stack_ovf, stack_unf;

  logic [13:0] rom [2048];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        stall;
    logic        skip;
    logic        chk_pc;
    logic [10:0] pc;
    logic [13:0] ir;
    logic        vld;
    logic [2:0]  sp;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  pc_fetch_unit #(.STACK_DEPTH(8), .RESET_VECTOR(11'h000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_in     (stall_in),
    .skip_in      (skip_in),
    .Rom_data_in  (Rom_data_in),
    .Rom_addr_out (Rom_addr_out),
    .ir_out       (ir_out),
    .ir_valid_out (ir_valid_out),
    .sp_out       (sp_out),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf)
  );

  assign Rom_data_in = rom[Rom_addr_out];
  always #5 clk = ~clk;

  function automatic logic is_xfer(input logic [13:0] w, input logic v);
    return v && (((w & 14'h3000) == 14'h2000) || (w == 14'h0008) ||
                 ((w & 14'h3C00) == 14'h3400));
  endfunction

  always @(posedge clk) begin
    if (rst_n && !stall_in)
      assert (!(skip_in && is_xfer(ir_out, ir_valid_out)))
        else $error("illegal skip_in with transfer in IR");
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic skip, input logic chk_pc,
                     input logic [10:0] pc, input logic [13:0] ir, input logic vld,
                     input logic [2:0] sp, input logic ovf, input logic unf);
    vec_t v;
    v.stall = stall; v.skip = skip; v.chk_pc = chk_pc; v.pc = pc; v.ir = ir;
    v.vld = vld; v.sp = sp; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      stall_in = tbl[i].stall;
      skip_in  = tbl[i].skip;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.chk_pc) check({tag, ".pc"}, i + 1, 32'(Rom_addr_out), 32'(e.pc));
      check({tag, ".ir"},  i + 1, 32'(ir_out),       32'(e.ir));
      check({tag, ".vld"}, i + 1, 32'(ir_valid_out), 32'(e.vld));
      check({tag, ".sp"},  i + 1, 32'(sp_out),       32'(e.sp));
      check({tag, ".ovf"}, i + 1, 32'(stack_ovf),    32'(e.ovf));
      check({tag, ".unf"}, i + 1, 32'(stack_unf),    32'(e.unf));
    end
    stall_in = 1'b0;
    skip_in  = 1'b0;
    tbl.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"},  0, 32'(Rom_addr_out), 32'h000);
    check({tag, ".ir"},  0, 32'(ir_out),       32'h0000);
    check({tag, ".vld"}, 0, 32'(ir_valid_out), 32'h0);
    check({tag, ".sp"},  0, 32'(sp_out),       32'h0);
    check({tag, ".ovf"}, 0, 32'(stack_ovf),    32'h0);
    check({tag, ".unf"}, 0, 32'(stack_unf),    32'h0);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 2048; a++) rom[a] = 14'h0000;
  endtask

  // Drop reset between edges and expect outputs to clear with no clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
  endtask

  initial begin
    // Linear fetch, CALL/RETURN, skip, GOTO with wrap.
    clear_rom();
    rom[0] = 14'h01A6; rom[1] = 14'h3006; rom[2] = 14'h00A5;
    rom[7] = 14'h2014; rom[11'h1E] = 14'h0008;
    rom[9] = 14'h0BA4; rom[11'hA] = 14'h1234; rom[11'hB] = 14'h0AAA;
    rom[11'hC] = 14'h2FFF; rom[11'h7FF] = 14'h0000;
    #12;
    check_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    add(0, 0, 1, 11'h001, 14'h01A6, 1, 0, 0, 0);
    add(0, 0, 1, 11'h002, 14'h3006, 1, 0, 0, 0);
    add(0, 0, 1, 11'h003, 14'h00A5, 1, 0, 0, 0);
    for (int a = 4; a <= 7; a++) add(0, 0, 1, 11'(a), 14'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 11'h008, 14'h2014, 1, 0, 0, 0);
    add(0, 0, 1, 11'h014, 14'h0000, 0, 1, 0, 0);
    for (int i = 0; i <= 10; i++)
      add(0, 0, 1, 11'(12'h15 + i), (i == 10) ? 14'h0008 : 14'h0000, 1, 1, 0, 0);
    add(0, 0, 1, 11'h008, 14'h0000, 0, 0, 0, 0);
    add(0, 0, 1, 11'h009, 14'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 11'h00A, 14'h0BA4, 1, 0, 0, 0);
    add(0, 1, 1, 11'h00B, 14'h0000, 0, 0, 0, 0);
    add(0, 0, 1, 11'h00C, 14'h0AAA, 1, 0, 0, 0);
    add(0, 0, 1, 11'h00D, 14'h2FFF, 1, 0, 0, 0);
    add(0, 0, 1, 11'h7FF, 14'h0000, 0, 0, 0, 0);
    add(0, 0, 1, 11'h000, 14'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 11'h001, 14'h01A6, 1, 0, 0, 0);
    run_tbl("main");

    // Nine nested CALLs: 9th overwrites stack[0]; the RETURN proves it.
    async_reset("rst1");
    clear_rom();
    for (int k = 1; k <= 9; k++) rom[k - 1] = 14'h2000 | 14'(k);
    rom[9] = 14'h0008;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      add(0, 0, 1, 11'(k), 14'h2000 | 14'(k), 1, 3'(k - 1), 0, 0);
      add(0, 0, 1, 11'(k), 14'h0000, 0, 3'(k), (k == 9), 0);
    end
    add(0, 0, 1, 11'h00A, 14'h0008, 1, 1, 1, 0);
    add(0, 0, 1, 11'h009, 14'h0000, 0, 0, 1, 0);
    run_tbl("ovf");

    // Mid-run reset must clear sticky ovf and sp asynchronously.
    async_reset("rst2");

    // RETURN straight out of reset underflows; popped value is undefined.
    clear_rom();
    rom[0] = 14'h0008;
    @(negedge clk);
    rst_n = 1'b1;
    add(0, 0, 1, 11'h001, 14'h0008, 1, 0, 0, 0);
    add(0, 0, 0, 11'h000, 14'h0000, 0, 7, 0, 1);
    run_tbl("unf");

    // Stall with a CALL in IR: frozen for 3 cycles, single push on release.
    async_reset("rst3");
    clear_rom();
    rom[1] = 14'h2010;
    rom[11'h10] = 14'h0ABC;
    @(negedge clk);
    rst_n = 1'b1;
    add(0, 0, 1, 11'h001, 14'h0000, 1, 0, 0, 0);
    add(0, 0, 1, 11'h002, 14'h2010, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 11'h002, 14'h2010, 1, 0, 0, 0);
    add(0, 0, 1, 11'h010, 14'h0000, 0, 1, 0, 0);
    add(0, 0, 1, 11'h011, 14'h0ABC, 1, 1, 0, 0);
    add(0, 0, 1, 11'h012, 14'h0000, 1, 1, 0, 0);
    run_tbl("stall");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction fetch unit for the 14-bit-instruction MCU core: owns the 11-bit program counter, drives the program ROM address, and reads the returned 14-bit instruction word into the instruction register. It also resolves the program-flow instructions GOTO, CALL, RETURN and RETLW through an 8-level hardware return stack, and applies skips requested by the execute stage. It sits between the program ROM and the decode/execute datapath; the ROM is combinational, so fetch and execute overlap in a 2-stage pipeline.

## Interface
- `STACK_DEPTH`, 8: return stack entries; must be a power of two.
- `RESET_VECTOR`, 11'h000: PC value after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  hold all state this cycle (PC, IR, stack, flags).
- `skip_in`  in  1  execute stage: the instruction now in IR skips its successor.
- `Rom_data_in`  in  14  instruction word at `Rom_addr_out`.
- `Rom_addr_out`  out  11  fetch address; equals the PC register.
- `ir_out`  out  14  instruction register (the instruction being executed).
- `ir_valid_out`  out  1  1 = `ir_out` is a fetched instruction; 0 = inserted bubble (14'h0000).
- `sp_out`  out  3  stack pointer; number of pushes mod 8.
- `stack_ovf`  out  1  sticky; set by a push when 8 entries are already in use.
- `stack_unf`  out  1  sticky; set by a pop when 0 entries are in use.

## Operation
- Decode on `ir_out`, gated by `ir_valid_out`:
  - GOTO: `10 1kkk kkkk kkkk`.
  - CALL: `10 0kkk kkkk kkkk`.
  - RETURN: 14'h0008.
  - RETLW: `11 01xx kkkk kkkk`. The fetch unit handles only the pop; the literal is loaded into W by execute.
- Per non-stalled cycle, first matching case wins:
  1. GOTO: PC <= k; IR <= bubble.
  2. CALL: push PC (already the address of the instruction after the CALL); PC <= k; IR <= bubble.
  3. RETURN/RETLW: pop; PC <= popped value; IR <= bubble.
  4. `skip_in`: PC <= PC+1; IR <= bubble, which discards the skipped word.
  5. Otherwise: IR <= `Rom_data_in`; PC <= PC+1.
- Bubble: `ir_out`=14'h0000 (NOP) and `ir_valid_out`=0. A bubble never triggers a transfer.
- PC increment is modulo 2^11: 11'h7FF wraps to 11'h000.
- Return stack is circular, matching the stack behaviour of the reference MCU family:
  - Push writes `stack[sp]` and then sets sp <= sp+1 mod 8.
  - Pop sets sp <= sp-1 mod 8 and reads `stack[sp-1]`.
  - A 9th nested push overwrites the oldest entry and sets `stack_ovf`.
  - A pop at depth 0 returns the wrapped entry and sets `stack_unf`.
  - A separate 0–8 depth counter, saturating at both ends, drives the flags.
  - Flags clear only on reset.
- `stall_in`=1: nothing changes, and `skip_in` plus the current decode are ignored. The same IR is re-evaluated once the stall is released.
- `skip_in` while IR holds a transfer instruction: the transfer wins and the skip is dropped. This combination is illegal from execute, and the bench flags it with an assertion.

## Timing
- Reset, asynchronous: PC=`RESET_VECTOR`, IR=14'h0000, `ir_valid_out`=0, sp=0, depth=0, `stack_ovf`=`stack_unf`=0. Stack contents are not reset.
- First edge after `rst_n` rises: IR <= ROM[RESET_VECTOR], PC <= RESET_VECTOR+1.
- `Rom_addr_out` is a register output, with no combinational path from any input.
- Sequential throughput: 1 instruction per cycle.
- GOTO/CALL/RETURN/RETLW/skip each cost 2 cycles, i.e. one bubble. The target instruction appears in IR 2 edges after the transfer entered IR.
- Stack push/pop and PC update commit on the same edge.

## Structure
- Shared package `mcu_pkg`:
  - Opcode match masks/values for GOTO, CALL, RETURN, RETLW.
  - `NOP_WORD`=14'h0000.
  - Width constants `PC_W`=11, `INSTR_W`=14.
- One sub-module: `return_stack`, covering the circular 8×11 register file, sp, the depth counter and the sticky flags, with push/pop/data ports.
- The top level holds PC, IR, decode and the next-PC priority mux.

## Test plan
- Reset and linear fetch:
  - Stimulus: ROM[0..2]=01A6,3006,00A5; release reset.
  - Required: `Rom_addr_out` reads 0,1,2,3 on successive cycles; `ir_out` reads 0000(invalid),01A6,3006,00A5.
- CALL/RETURN:
  - Stimulus: ROM[7]=2014, ROM[0x1E]=0008.
  - Required on the CALL: bubble, PC=0x014, stack[0]=0x008, sp=1.
  - Required on the RETURN: bubble, PC=0x008, sp=0. Next valid IR = ROM[8].
- Skip:
  - Stimulus: ROM[9]=0BA4 in IR with `skip_in`=1.
  - Required: ROM[0xA] is replaced by a bubble; ROM[0xB] executes next.
- GOTO with wrap:
  - Stimulus: GOTO 0x7FF, with ROM[0x7FF]=NOP.
  - Required: after 0x7FF, `Rom_addr_out` wraps to 0x000.
- Stack overflow and underflow:
  - Stimulus: 9 nested CALLs.
  - Required: `stack_ovf`=1, sp=1, and the 9th return address has overwritten stack[0].
  - Separately: RETURN from reset sets `stack_unf`=1.
- Stall and mid-operation reset:
  - Stimulus: hold `stall_in` for 3 cycles during a CALL in IR.
  - Required: PC, IR and sp are frozen; the push happens once, after release.
  - Stimulus: assert `rst_n`=0 mid-burst.
  - Required: all outputs return to their reset values immediately, without waiting for a clock edge.
